// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared types and constants for the LCD line scheduler: the
//            scheduler and byte-engine state encodings, the HD44780 power-up
//            command ROM and the DDRAM row base addresses.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Scheduler states
  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_ADDR = 3'd2,
    ST_CHAR = 3'd3,
    ST_WAIT = 3'd4,
    ST_GAP  = 3'd5,
    ST_DONE = 3'd6
  } sched_state_e;

  // What kind of byte is currently in flight, decides the follow-up state
  typedef enum logic [1:0] {
    KIND_INIT = 2'd0,
    KIND_ADDR = 2'd1,
    KIND_CHAR = 2'd2
  } byte_kind_e;

  // Byte engine states
  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_STRB = 3'd1,
    TX_SKIP = 3'd2,
    TX_WAIT = 3'd3,
    TX_GAP  = 3'd4
  } tx_state_e;

  // Power-up command ROM: 4-bit bus / 2 lines, display on, clear, entry mode
  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  // Set-DDRAM-address commands for the start of each row
  localparam logic [7:0] ROW0_BASE = 8'h80;
  localparam logic [7:0] ROW1_BASE = 8'hC0;

  // Replacement for NUL when padding is enabled
  localparam logic [7:0] PAD_CHAR = 8'h20;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    init_cmd = CMD_FUNC_SET;
      2'd1:    init_cmd = CMD_DISP_ON;
      2'd2:    init_cmd = CMD_CLEAR;
      default: init_cmd = CMD_ENTRY;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_byte_tx
// Purpose  : One-byte write handshake toward the LCD_write nibble engine:
//            1-cycle strobe, one cycle where busy is ignored (engine may not
//            have raised it yet), wait for busy low, then GAP_CYCLES idle
//            cycles before reporting completion with a 1-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_byte_tx #(
  parameter int GAP_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       wr_busy,
  output logic       wr_strb,
  output logic [7:0] wr_data,
  output logic       wr_rs,
  output logic       in_gap,
  output logic       done
);
  import lcd_pkg::*;

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strb_q, strb_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             done_q, done_d;

  // Next-state logic for the strobe / busy-wait / gap sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strb_d  = 1'b0;
    data_d  = data_q;
    rs_d    = rs_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          strb_d  = 1'b1;
          data_d  = data;
          rs_d    = rs;
          state_d = TX_STRB;
        end
      end
      TX_STRB: state_d = TX_SKIP;
      TX_SKIP: state_d = TX_WAIT;
      TX_WAIT: begin
        if (!wr_busy) begin
          if (GAP_CYCLES == 0) begin
            done_d  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = TX_GAP;
          end
        end
      end
      TX_GAP: begin
        if (cnt_q == LAST_CNT) begin
          done_d  = 1'b1;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      strb_q  <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      done_q  <= done_d;
    end
  end

  assign wr_strb = strb_q;
  assign wr_data = data_q;
  assign wr_rs   = rs_q;
  assign in_gap  = (state_q == TX_GAP);
  assign done    = done_q;

endmodule
`default_nettype wire

// File: rtl/lcd_line_sched.sv
`default_nettype none
// ============================================================================
// Module   : lcd_line_sched
// Purpose  : Runs the LCD power-up sequence, then arbitrates two line
//            requesters round-robin and writes one full line (row address
//            plus LINE_LEN characters) for the granted owner.
// Config   : LCD_SCHED_NUL_PAD_EN - when defined, NUL characters are written
//            as spaces and the full line is always sent; otherwise the line
//            ends at the first NUL.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_line_sched #(
  parameter int GAP_CYCLES = 8,
  parameter int LINE_LEN   = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0,
  input  logic       req1,
  input  logic       line0,
  input  logic       line1,
  input  logic [7:0] char0,
  input  logic [7:0] char1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] char_idx,
  output logic       done0,
  output logic       done1,
  output logic       wr_strb,
  output logic [7:0] wr_data,
  output logic       wr_rs,
  input  logic       wr_busy,
  output logic       init_done
);
  import lcd_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

  sched_state_e state_q, state_d;
  byte_kind_e   kind_q, kind_d;
  logic [1:0]   step_q, step_d;
  logic         owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
  logic         row_q, row_d;
  logic         prio_q, prio_d;     // 1 = requester 1 wins a tie
  logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic         done0_q, done0_d, done1_q, done1_d;
  logic [3:0]   char_idx_q, char_idx_d;
  logic         init_done_q, init_done_d;

  logic         tx_start, tx_rs, tx_gap, tx_done, line_end;
  logic [7:0]   tx_data, char_sel;

  assign char_sel = owner_q ? char1 : char0;

  lcd_byte_tx #(.GAP_CYCLES(GAP_CYCLES)) u_tx (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (tx_start),
    .data    (tx_data),
    .rs      (tx_rs),
    .wr_busy (wr_busy),
    .wr_strb (wr_strb),
    .wr_data (wr_data),
    .wr_rs   (wr_rs),
    .in_gap  (tx_gap),
    .done    (tx_done)
  );

  // Scheduler next-state: init ROM walk, arbitration, address and char issue
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    step_d      = step_q;
    owner_d     = owner_q;
    row_d       = row_q;
    prio_d      = prio_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    char_idx_d  = char_idx_q;
    init_done_d = init_done_q;
    tx_start    = 1'b0;
    tx_data     = 8'h00;
    tx_rs       = 1'b0;
    line_end    = 1'b0;
    case (state_q)
      ST_INIT: begin
        tx_start = 1'b1;
        tx_data  = init_cmd(step_q);
        kind_d   = KIND_INIT;
        state_d  = ST_WAIT;
      end
      ST_IDLE: begin
        char_idx_d = 4'd0;
        if (req0 && (!req1 || !prio_q)) begin
          owner_d = 1'b0;
          row_d   = line0;
          gnt0_d  = 1'b1;
          prio_d  = 1'b1;
          state_d = ST_ADDR;
        end else if (req1) begin
          owner_d = 1'b1;
          row_d   = line1;
          gnt1_d  = 1'b1;
          prio_d  = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        tx_start = 1'b1;
        tx_data  = row_q ? ROW1_BASE : ROW0_BASE;
        kind_d   = KIND_ADDR;
        state_d  = ST_WAIT;
      end
      ST_CHAR: begin
`ifdef LCD_SCHED_NUL_PAD_EN
        tx_start = 1'b1;
        tx_rs    = 1'b1;
        tx_data  = (char_sel == 8'h00) ? PAD_CHAR : char_sel;
        kind_d   = KIND_CHAR;
        state_d  = ST_WAIT;
`else
        if (char_sel == 8'h00) begin
          line_end = 1'b1;
        end else begin
          tx_start = 1'b1;
          tx_rs    = 1'b1;
          tx_data  = char_sel;
          kind_d   = KIND_CHAR;
          state_d  = ST_WAIT;
        end
`endif
      end
      ST_WAIT, ST_GAP: begin
        if (tx_done) begin
          case (kind_q)
            KIND_INIT: begin
              if (step_q == 2'd3) begin
                init_done_d = 1'b1;
                state_d     = ST_IDLE;
              end else begin
                step_d  = step_q + 2'd1;
                state_d = ST_INIT;
              end
            end
            KIND_ADDR: state_d = ST_CHAR;
            default: begin
              if (char_idx_q == LAST_IDX) begin
                line_end = 1'b1;
              end else begin
                char_idx_d = char_idx_q + 4'd1;
                state_d    = ST_CHAR;
              end
            end
          endcase
        end else if (tx_gap) begin
          state_d = ST_GAP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    // Line complete: pulse owner's done and release the grant together
    if (line_end) begin
      done0_d    = ~owner_q;
      done1_d    = owner_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      char_idx_d = 4'd0;
      state_d    = ST_DONE;
    end
  end

  // Scheduler state and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_INIT;
      kind_q      <= KIND_INIT;
      step_q      <= 2'd0;
      owner_q     <= 1'b0;
      row_q       <= 1'b0;
      prio_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      char_idx_q  <= 4'd0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      step_q      <= step_d;
      owner_q     <= owner_d;
      row_q       <= row_d;
      prio_q      <= prio_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      char_idx_q  <= char_idx_d;
      init_done_q <= init_done_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign char_idx  = char_idx_q;
  assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_line_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_line_sched
// Purpose  : Scoreboard bench for lcd_line_sched. Expected LCD writes and
//            done pulses are queued by the stimulus; a negedge monitor pops
//            and compares on every wr_strb / done. A 5-cycle busy model
//            stands in for the LCD_write engine.
// Config   : LCD_SCHED_NUL_PAD_EN selects the padded NUL expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_line_sched;

  localparam int GAP  = 8;
  localparam int LINE = 16;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } wr_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req0, req1, line0, line1;
  logic [7:0] char0, char1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] char_idx;
  logic       wr_strb, wr_rs, wr_busy, init_done;
  logic [7:0] wr_data;

  logic [7:0] txt0 [16];
  logic [7:0] txt1 [16];

  wr_t exp_q[$];
  int  exp_done[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_strb = -1;
  int  busy_cnt = 0;
  bit  prev_done = 1'b0;
  wr_t got_w, exp_w;
  int  who;

  always #5 CLK = ~CLK;

  assign char0   = txt0[char_idx];
  assign char1   = txt1[char_idx];
  assign wr_busy = (busy_cnt != 0);

  lcd_line_sched #(.GAP_CYCLES(GAP), .LINE_LEN(LINE)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req0      (req0),
    .req1      (req1),
    .line0     (line0),
    .line1     (line1),
    .char0     (char0),
    .char1     (char1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .char_idx  (char_idx),
    .done0     (done0),
    .done1     (done1),
    .wr_strb   (wr_strb),
    .wr_data   (wr_data),
    .wr_rs     (wr_rs),
    .wr_busy   (wr_busy),
    .init_done (init_done)
  );

  // LCD_write stand-in: busy for 5 cycles after every strobe
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET)        busy_cnt <= 0;
    else if (wr_strb) busy_cnt <= 5;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Monitor: compare every strobe and done pulse against the scoreboard
  always @(negedge CLK) begin
    if (RESET) begin
      last_strb = -1;
      prev_done = 1'b0;
    end else begin
      if (wr_strb) begin
        checks++;
        got_w = '{rs: wr_rs, data: wr_data};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got rs=%0b data=%02h, expected no write", wr_rs, wr_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w != exp_w) begin
            errors++;
            $display("FAIL wr_byte: got rs=%0b data=%02h, expected rs=%0b data=%02h",
                     got_w.rs, got_w.data, exp_w.rs, exp_w.data);
          end
        end
        if (last_strb >= 0) begin
          checks++;
          if (cyc - last_strb < GAP + 1) begin
            errors++;
            $display("FAIL strb_spacing: got %0d cycles, expected >= %0d", cyc - last_strb, GAP + 1);
          end
        end
        last_strb = cyc;
      end
      if (gnt0 || gnt1) begin
        checks++;
        if (!init_done || (gnt0 && gnt1)) begin
          errors++;
          $display("FAIL gnt_legal: got gnt0=%0b gnt1=%0b init_done=%0b, expected one-hot after init",
                   gnt0, gnt1, init_done);
        end
      end
      if (done0 || done1) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done0=%0b done1=%0b, expected none", done0, done1);
        end else begin
          who = exp_done.pop_front();
          if ({done1, done0} != ((who == 1) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL done_owner: got done1,done0=%b%b, expected owner %0d", done1, done0, who);
          end
        end
        checks++;
        if (gnt0 || gnt1) begin
          errors++;
          $display("FAIL gnt_drop: got gnt0=%0b gnt1=%0b with done, expected 0", gnt0, gnt1);
        end
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_width: got done high 2 cycles, expected 1-cycle pulse");
        end
      end
      prev_done = done0 || done1;
    end
  end

  task automatic push_wr(input logic rs, input logic [7:0] d);
    exp_q.push_back('{rs: rs, data: d});
  endtask

  task automatic push_init();
    push_wr(1'b0, 8'h28);
    push_wr(1'b0, 8'h0C);
    push_wr(1'b0, 8'h01);
    push_wr(1'b0, 8'h06);
  endtask

  task automatic set_text(input int sel, input string s);
    logic [7:0] c;
    for (int i = 0; i < 16; i++) begin
      c = (i < s.len()) ? s[i] : 8'h00;
      if (sel == 0) txt0[i] = c;
      else          txt1[i] = c;
    end
  endtask

  // Expected row address, characters (NUL rule by build) and done owner
  task automatic push_line(input int sel, input logic row);
    logic [7:0] c;
    push_wr(1'b0, row ? 8'hC0 : 8'h80);
    for (int i = 0; i < LINE; i++) begin
      c = (sel == 0) ? txt0[i] : txt1[i];
`ifdef LCD_SCHED_NUL_PAD_EN
      push_wr(1'b1, (c == 8'h00) ? 8'h20 : c);
`else
      if (c == 8'h00) break;
      push_wr(1'b1, c);
`endif
    end
    exp_done.push_back(sel);
  endtask

  task automatic wait_for_done(input int sel, input string name);
    int n = 0;
    while (!((sel == 0) ? done0 : done1) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s: got no done%0d within 2000 cycles, expected a pulse", name, sel);
    end
    if (sel == 0) req0 = 1'b0;
    else          req1 = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 500) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL %s: got init_done=0 after 500 cycles, expected 1", name);
    end
  endtask

  task automatic check_drained(input string name);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d writes and %0d dones outstanding, expected 0 and 0",
               name, exp_q.size(), exp_done.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [18:0] v;
    v = {gnt0, gnt1, done0, done1, wr_strb, wr_rs, init_done, char_idx, wr_data};
    checks++;
    if (v != 19'd0) begin
      errors++;
      $display("FAIL %s: got gnt=%b%b done=%b%b strb=%b rs=%b init_done=%b idx=%0d data=%02h, expected all 0",
               name, gnt0, gnt1, done0, done1, wr_strb, wr_rs, init_done, char_idx, wr_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; req0 = 1'b0; req1 = 1'b0; line0 = 1'b0; line1 = 1'b0;
    set_text(0, "");
    set_text(1, "");
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_state");

    // Power-up with req0 already waiting: no grant until init finishes
    push_init();
    set_text(0, "INITWAIT");
    line0 = 1'b0;
    req0  = 1'b1;
    push_line(0, 1'b0);
    RESET = 1'b0;
    wait_init("init_seq");
    wait_for_done(0, "init_then_req0");
    check_drained("init_drain");

    // Single line on the bottom row
    set_text(1, "HELLO WORLD     ");
    line1 = 1'b1;
    req1  = 1'b1;
    push_line(1, 1'b1);
    wait_for_done(1, "single_done");
    check_drained("single_drain");

    // Contention A: last grant was req1, so req0 goes first
    set_text(0, "ROW0 FIRST......");
    set_text(1, "ROW1 SECOND.....");
    line0 = 1'b0; line1 = 1'b1;
    push_line(0, 1'b0);
    push_line(1, 1'b1);
    req0 = 1'b1; req1 = 1'b1;
    wait_for_done(0, "contA_first");
    wait_for_done(1, "contA_second");
    check_drained("contA_drain");

    // Early drop: req0 released after 3 characters, line still completes
    set_text(0, "EARLY DROP LINE!");
    line0 = 1'b1;
    push_line(0, 1'b1);
    req0 = 1'b1;
    begin
      int n = 0;
      while (char_idx != 4'd3 && n < 2000) begin
        @(negedge CLK);
        n++;
      end
    end
    req0 = 1'b0;
    wait_for_done(0, "drop_done");
    check_drained("drop_drain");

    // NUL handling: "AB" then NUL, hand-computed expectations
    set_text(0, "AB");
    line0 = 1'b0;
    push_wr(1'b0, 8'h80);
    push_wr(1'b1, 8'h41);
    push_wr(1'b1, 8'h42);
`ifdef LCD_SCHED_NUL_PAD_EN
    for (int i = 0; i < 14; i++) push_wr(1'b1, 8'h20);
`endif
    exp_done.push_back(0);
    req0 = 1'b1;
    wait_for_done(0, "nul_done");
    check_drained("nul_drain");

    // Contention B: last grant was req0, so req1 goes first now
    set_text(0, "SECOND NOW      ");
    set_text(1, "FIRST NOW       ");
    line0 = 1'b1; line1 = 1'b0;
    push_line(1, 1'b0);
    push_line(0, 1'b1);
    req0 = 1'b1; req1 = 1'b1;
    wait_for_done(1, "contB_first");
    wait_for_done(0, "contB_second");
    check_drained("contB_drain");

    // Reset while character 7 is being strobed
    set_text(1, "0123456789ABCDEF");
    line1 = 1'b0;
    push_line(1, 1'b0);
    req1 = 1'b1;
    begin
      int n = 0;
      while (!(wr_strb && char_idx == 4'd7) && n < 2000) begin
        @(negedge CLK);
        n++;
      end
      checks++;
      if (n >= 2000) begin
        errors++;
        $display("FAIL midline_reach: got idx=%0d, expected strobe at index 7", char_idx);
      end
    end
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_outputs("reset_midline");
    exp_q.delete();
    exp_done.delete();
    req1 = 1'b0;
    push_init();
    @(negedge CLK);
    RESET = 1'b0;
    wait_init("reinit_seq");
    repeat (GAP + 10) @(negedge CLK);
    check_drained("reinit_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
